// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle MIPS-style control FSM; SHIFT_INSTR_EN adds SLL/SRL decode
module multicycle_controller #(
    parameter int MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECUTE = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [3:0] wait_cnt;
    logic       wait_state;
    logic       wait_done;
    logic       funct_ok;
    logic [2:0] funct_alu;
    logic       pcwrite;
    logic       branch;
    logic       irwrite_c;
    logic       regwrite_c;
    logic       memwrite_c;
    logic       illegal_c;

    // Memory-facing states stretch by MEM_WAIT cycles; the last one carries the strobe.
    assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign wait_done  = (wait_cnt == WAIT_LAST);

    // R-type funct decode; unsupported codes leave funct_ok low and alu select at 000.
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_AND;
        case (funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
`ifdef SHIFT_INSTR_EN
            6'b000000: funct_alu = 3'b100;
            6'b000010: funct_alu = 3'b101;
`endif
            default:   funct_ok  = 1'b0;
        endcase
    end

    // Next-state selection; unknown opcodes and unused codes fall back to FETCH.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:   if (wait_done) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (wait_done) state_d = S_MEMWB;
            S_MEMWR:   if (wait_done) state_d = S_FETCH;
            S_EXECUTE: state_d = funct_ok ? S_ALUWB : S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // State and wait counter; the counter returns to zero whenever a wait state is left.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_FETCH;
            wait_cnt <= 4'd0;
        end else begin
            state_q <= state_d;
            if (wait_state && !wait_done) begin
                wait_cnt <= wait_cnt + 4'd1;
            end else begin
                wait_cnt <= 4'd0;
            end
        end
    end

    // Per-state control decode, purely combinational from state, counter and inputs.
    always_comb begin
        irwrite_c  = 1'b0;
        regwrite_c = 1'b0;
        memwrite_c = 1'b0;
        illegal_c  = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = 3'b000;
        case (state_q)
            S_FETCH: begin
                alusrcb    = 2'b01;
                alucontrol = ALU_ADD;
                irwrite_c  = wait_done;
                pcwrite    = wait_done;
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = ALU_ADD;
                illegal_c  = !((op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
                               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J));
            end
            S_MEMADR, S_ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
            end
            S_MEMRD:   iord = 1'b1;
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_c = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite_c = wait_done;
            end
            S_EXECUTE: begin
                alusrca    = 1'b1;
                alucontrol = funct_alu;
                illegal_c  = !funct_ok;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                regwrite_c = 1'b1;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                branch     = 1'b1;
            end
            S_ADDIWB:  regwrite_c = 1'b1;
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // Write strobes are masked while reset is held so no partial write can escape.
    assign pcen     = reset_n & (pcwrite | (branch & zero));
    assign irwrite  = reset_n & irwrite_c;
    assign regwrite = reset_n & regwrite_c;
    assign memwrite = reset_n & memwrite_c;
    assign illegal  = reset_n & illegal_c;
    assign state    = state_q;

endmodule
